// File: rtl/pc_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_seq_pkg;

  localparam int CNT_W_DEF       = 10;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_INC    = 3'd1,
    OP_DEC    = 3'd2,
    OP_JUMP   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_STEP_N = 3'd6,
    OP_CLR    = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Command handshake, counter strobes and status of the sequencer, as one bundle.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEPTH_W = $clog2(STACK_DEPTH_DEF + 1)
);

  logic               cmd_valid;
  logic               cmd_ready;
  op_t                cmd_op;
  logic [CNT_W-1:0]   cmd_arg;
  logic [CNT_W-1:0]   ctr_cnt;
  logic               ctr_en;
  logic               ctr_load;
  logic               ctr_updn;
  logic [CNT_W-1:0]   ctr_data;
  logic               busy;
  logic               done;
  logic               err;
  logic [DEPTH_W-1:0] depth;

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, ctr_cnt,
    output cmd_ready, ctr_en, ctr_load, ctr_updn, ctr_data, busy, done, err, depth
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg, ctr_cnt,
    input  cmd_ready, ctr_en, ctr_load, ctr_updn, ctr_data, busy, done, err, depth
  );

endinterface

// File: rtl/pc_sequencer_stack.sv
// Return-address LIFO; the caller never pushes and pops in the same cycle.
module pc_stack #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  data_out,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] cnt;

  assign full     = (cnt == DW'(DEPTH));
  assign empty    = (cnt == '0);
  assign depth    = cnt;
  assign data_out = empty ? '0 : mem[AW'(cnt - DW'(1))];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (push && !full)   cnt <= cnt + DW'(1);
    else if (pop && !empty)   cnt <= cnt - DW'(1);
  end

  // NOTE: storage is not reset; entries above the fill level are never read.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[cnt[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Turns handshaked commands into registered program-counter strobes, with call/return LIFO.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic           clk50m,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   step_cnt, step_n;
  logic               en_q, en_n, load_q, load_n, updn_q, updn_n;
  logic [CNT_W-1:0]   data_q, data_n;
  logic               done_q, done_n, err_q, err_n;
  logic               push_q, push_n, pop_q, pop_n, clr_q, clr_n;
  logic [CNT_W-1:0]   ret_q, ret_n;

  logic               stk_full, stk_empty;
  logic [CNT_W-1:0]   stk_top;
  logic [DEPTH_W-1:0] stk_depth;

  // Stack actions are armed at acceptance and fire at the edge ending the single EXEC cycle.
  pc_stack #(.W(CNT_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk      (clk50m),
    .rst      (rst),
    .push     (state == EXEC && push_q),
    .pop      (state == EXEC && pop_q),
    .clr      (state == EXEC && clr_q),
    .data_in  (ret_q),
    .data_out (stk_top),
    .full     (stk_full),
    .empty    (stk_empty),
    .depth    (stk_depth)
  );

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      en_q     <= 1'b0;
      load_q   <= 1'b0;
      updn_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      clr_q    <= 1'b0;
      ret_q    <= '0;
    end else begin
      state    <= state_n;
      step_cnt <= step_n;
      en_q     <= en_n;
      load_q   <= load_n;
      updn_q   <= updn_n;
      data_q   <= data_n;
      done_q   <= done_n;
      err_q    <= err_n;
      push_q   <= push_n;
      pop_q    <= pop_n;
      clr_q    <= clr_n;
      ret_q    <= ret_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    step_n  = step_cnt;
    en_n    = 1'b0;
    load_n  = 1'b0;
    updn_n  = 1'b0;
    data_n  = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    push_n  = push_q;
    pop_n   = pop_q;
    clr_n   = clr_q;
    ret_n   = ret_q;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_n = EXEC;
          step_n  = '0;
          done_n  = 1'b1;
          push_n  = 1'b0;
          pop_n   = 1'b0;
          clr_n   = 1'b0;
          unique case (bus.cmd_op)
            OP_NOP: ;
            OP_INC: en_n = 1'b1;
            OP_DEC: begin
              en_n   = 1'b1;
              updn_n = 1'b1;
            end
            OP_JUMP: begin
              load_n = 1'b1;
              data_n = bus.cmd_arg;
            end
            OP_CALL: begin
              if (stk_full) err_n = 1'b1;
              else begin
                load_n = 1'b1;
                data_n = bus.cmd_arg;
                push_n = 1'b1;
                ret_n  = bus.ctr_cnt + CNT_W'(1);
              end
            end
            OP_RET: begin
              if (stk_empty) err_n = 1'b1;
              else begin
                load_n = 1'b1;
                data_n = stk_top;
                pop_n  = 1'b1;
              end
            end
            OP_STEP_N: begin
              if (bus.cmd_arg != '0) begin
                en_n   = 1'b1;
                step_n = bus.cmd_arg - CNT_W'(1);
                done_n = (bus.cmd_arg == CNT_W'(1));
              end
            end
            OP_CLR: begin
              load_n = 1'b1;
              clr_n  = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        // step_cnt holds the enable cycles still owed after the current one.
        if (step_cnt != '0) begin
          en_n   = 1'b1;
          step_n = step_cnt - CNT_W'(1);
          done_n = (step_cnt == CNT_W'(1));
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == EXEC);
  assign bus.ctr_en    = en_q;
  assign bus.ctr_load  = load_q;
  assign bus.ctr_updn  = updn_q;
  assign bus.ctr_data  = data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.depth     = stk_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a command-level reference model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int CNT_W       = 10;
  localparam int STACK_DEPTH = 4;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);
  localparam int MOD         = 1 << CNT_W;

  logic clk50m = 1'b0;
  logic rst;

  pc_sequencer_if #(.CNT_W(CNT_W), .DEPTH_W(DEPTH_W)) bus ();

  pc_sequencer #(.CNT_W(CNT_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #10 clk50m = ~clk50m;

  // The program counter the sequencer drives.
  logic [CNT_W-1:0] pc;
  always @(posedge clk50m or posedge rst) begin
    if (rst)               pc <= '0;
    else if (bus.ctr_load) pc <= bus.ctr_data;
    else if (bus.ctr_en)   pc <= bus.ctr_updn ? pc - 1'b1 : pc + 1'b1;
  end
  assign bus.ctr_cnt = pc;

  int compared   = 0;
  int mismatched = 0;
  int model_pc   = 0;
  int model_stack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, 32'(bus.cmd_ready), 1);
    check({tag, " busy"},  32'(bus.busy), 0);
    check({tag, " en"},    32'(bus.ctr_en), 0);
    check({tag, " load"},  32'(bus.ctr_load), 0);
    check({tag, " updn"},  32'(bus.ctr_updn), 0);
    check({tag, " data"},  32'(bus.ctr_data), 0);
    check({tag, " done"},  32'(bus.done), 0);
    check({tag, " err"},   32'(bus.err), 0);
    check({tag, " depth"}, 32'(bus.depth), model_stack.size());
    check({tag, " cnt"},   32'(bus.ctr_cnt), model_pc);
  endtask

  // Issue one command at a negedge and follow it cycle by cycle back to IDLE.
  task automatic do_cmd(input op_t op, input int arg_in);
    int    arg, n, data_e, waited;
    bit    en_e, load_e, updn_e, err_e;
    string tag;
    arg    = arg_in % MOD;
    tag    = $sformatf("%s(0x%0h)", op.name(), arg);
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk50m);
      waited++;
    end
    check({tag, " ready_wait"}, 32'(bus.cmd_ready), 1);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = CNT_W'(arg);

    n = 1; data_e = 0; en_e = 0; load_e = 0; updn_e = 0; err_e = 0;
    case (op)
      OP_INC:  en_e = 1;
      OP_DEC:  begin en_e = 1; updn_e = 1; end
      OP_JUMP: begin load_e = 1; data_e = arg; end
      OP_CALL: begin
        if (model_stack.size() == STACK_DEPTH) err_e = 1;
        else begin
          load_e = 1;
          data_e = arg;
          model_stack.push_back((model_pc + 1) % MOD);
        end
      end
      OP_RET: begin
        if (model_stack.size() == 0) err_e = 1;
        else begin
          load_e = 1;
          data_e = model_stack.pop_back();
        end
      end
      OP_STEP_N: if (arg > 0) begin en_e = 1; n = arg; end
      OP_CLR:  begin load_e = 1; data_e = 0; model_stack.delete(); end
      default: ;
    endcase

    for (int i = 1; i <= n; i++) begin
      @(negedge clk50m);
      // Garbage on the command inputs while executing must be ignored.
      bus.cmd_valid = (i != n);
      bus.cmd_op    = op_t'($urandom_range(0, 7));
      bus.cmd_arg   = CNT_W'($urandom_range(0, MOD - 1));
      check({tag, " x_ready"}, 32'(bus.cmd_ready), 0);
      check({tag, " x_busy"},  32'(bus.busy), 1);
      check({tag, " x_en"},    32'(bus.ctr_en), en_e);
      check({tag, " x_load"},  32'(bus.ctr_load), load_e);
      check({tag, " x_updn"},  32'(bus.ctr_updn), updn_e);
      check({tag, " x_data"},  32'(bus.ctr_data), data_e);
      check({tag, " x_done"},  32'(bus.done), (i == n));
      check({tag, " x_err"},   32'(bus.err), err_e);
      if (load_e)    model_pc = data_e;
      else if (en_e) model_pc = updn_e ? (model_pc + MOD - 1) % MOD : (model_pc + 1) % MOD;
    end
    @(negedge clk50m);
    check_idle({tag, " end"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_arg   = '0;
    repeat (2) @(negedge clk50m);
    check("rst busy", 32'(bus.busy), 0);
    check("rst en",   32'(bus.ctr_en), 0);
    check("rst load", 32'(bus.ctr_load), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst err",  32'(bus.err), 0);
    check("rst depth", 32'(bus.depth), 0);
    rst = 1'b0;
    @(negedge clk50m);
    check_idle("post_reset");

    repeat (3) do_cmd(OP_INC, 0);
    check("inc3 cnt", 32'(bus.ctr_cnt), 3);

    do_cmd(OP_JUMP, 'h2A0);
    do_cmd(OP_DEC, 0);
    check("dec cnt", 32'(bus.ctr_cnt), 'h29F);

    do_cmd(OP_JUMP, 'h3FF);
    do_cmd(OP_CALL, 'h100);
    check("call depth", 32'(bus.depth), 1);
    do_cmd(OP_RET, 0);
    check("ret wrap cnt", 32'(bus.ctr_cnt), 0);

    for (int i = 0; i < 5; i++) do_cmd(OP_CALL, 'h040 * (i + 1));
    check("full depth", 32'(bus.depth), STACK_DEPTH);
    for (int i = 0; i < 5; i++) do_cmd(OP_RET, 0);
    check("empty depth", 32'(bus.depth), 0);

    do_cmd(OP_JUMP, 10);
    do_cmd(OP_STEP_N, 5);
    check("step5 cnt", 32'(bus.ctr_cnt), 15);
    do_cmd(OP_STEP_N, 0);
    do_cmd(OP_STEP_N, 1);
    do_cmd(OP_CALL, 'h050);
    do_cmd(OP_CLR, 0);

    // Reset in the 3rd cycle of a long step sequence.
    do_cmd(OP_CALL, 'h050);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STEP_N;
    bus.cmd_arg   = CNT_W'(8);
    @(negedge clk50m);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk50m);
    check("step8 c3 en", 32'(bus.ctr_en), 1);
    rst = 1'b1;
    #1;
    check("midrst en",    32'(bus.ctr_en), 0);
    check("midrst load",  32'(bus.ctr_load), 0);
    check("midrst data",  32'(bus.ctr_data), 0);
    check("midrst busy",  32'(bus.busy), 0);
    check("midrst depth", 32'(bus.depth), 0);
    @(negedge clk50m);
    rst = 1'b0;
    model_pc = 0;
    model_stack.delete();
    @(negedge clk50m);
    check_idle("after_midrst");
    do_cmd(OP_INC, 0);
    check("after_midrst cnt", 32'(bus.ctr_cnt), 1);

    for (int k = 0; k < 120; k++) begin
      op_t op;
      int  arg;
      op  = op_t'($urandom_range(0, 7));
      arg = (op == OP_STEP_N) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, MOD - 1));
      do_cmd(op, arg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
